// File: rtl/tow_key_pulser_if.sv
// Player-button and move-pulse bundle between the board keys and the tug-of-war playfield.
interface tow_key_pulser_if;
  logic keyL;
  logic keyR;
  logic freeze;
  logic L;
  logic R;
  logic tie;

  modport master (output keyL, keyR, freeze, input L, R, tie);
  modport slave  (input keyL, keyR, freeze, output L, R, tie);
endinterface

// File: rtl/tow_key_pulser.sv
// Synchronises and debounces two active-low player buttons and emits one move pulse per
// press; presses confirmed on the same clock become a single tie pulse.
module tow_key_pulser #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  tow_key_pulser_if.slave   bus
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_t;

  logic [1:0] w_key;
  logic [1:0] w_confirm;
  logic       r_l;
  logic       r_r;
  logic       r_tie;

  // Index 0 is the left player, index 1 the right player.
  assign w_key = {bus.keyR, bus.keyL};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      logic [SYNC_STAGES-1:0] r_sync;
      state_t                 r_state;
      logic [CNT_W-1:0]       r_cnt;
      logic                   r_confirm;
      logic                   w_s;

      assign w_s = r_sync[SYNC_STAGES-1];

      // Synchroniser resets to "pressed" so a key held through reset never fires.
      always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
          r_sync <= '0;
        end else begin
          r_sync <= {r_sync[SYNC_STAGES-2:0], w_key[gi]};
        end
      end

      always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
          r_state   <= HELD;
          r_cnt     <= '0;
          r_confirm <= 1'b0;
        end else begin
          r_confirm <= 1'b0;
          case (r_state)
            IDLE: begin
              if (!w_s) begin
                if (CNT_ONE == CNT_MAX) begin
                  r_state   <= HELD;
                  r_confirm <= 1'b1;
                end else begin
                  r_state <= PRESS_CHK;
                  r_cnt   <= CNT_ONE;
                end
              end
            end
            PRESS_CHK: begin
              if (w_s) begin
                r_state <= IDLE;
              end else begin
                r_cnt <= r_cnt + CNT_ONE;
                if (r_cnt + CNT_ONE == CNT_MAX) begin
                  r_state   <= HELD;
                  r_confirm <= 1'b1;
                end
              end
            end
            HELD: begin
              if (w_s) begin
                if (CNT_ONE == CNT_MAX) begin
                  r_state <= IDLE;
                end else begin
                  r_state <= REL_CHK;
                  r_cnt   <= CNT_ONE;
                end
              end
            end
            REL_CHK: begin
              if (!w_s) begin
                r_state <= HELD;
              end else begin
                r_cnt <= r_cnt + CNT_ONE;
                if (r_cnt + CNT_ONE == CNT_MAX) begin
                  r_state <= IDLE;
                end
              end
            end
            default: r_state <= HELD;
          endcase
        end
      end

      assign w_confirm[gi] = r_confirm;
    end
  endgenerate

  // A confirm arriving during freeze is dropped, not held for later.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_l   <= 1'b0;
      r_r   <= 1'b0;
      r_tie <= 1'b0;
    end else if (bus.freeze) begin
      r_l   <= 1'b0;
      r_r   <= 1'b0;
      r_tie <= 1'b0;
    end else begin
      r_l   <= w_confirm[0] & ~w_confirm[1];
      r_r   <= w_confirm[1] & ~w_confirm[0];
      r_tie <= w_confirm[0] &  w_confirm[1];
    end
  end

  assign bus.L   = r_l;
  assign bus.R   = r_r;
  assign bus.tie = r_tie;

endmodule
